spi_initiator: RTL and testbench
================================

# spi_initiator

Serial-peripheral initiator that drives the far end of the team's shift-register peripheral interface. It generates the peripheral clock (`sclk`), an active-low chip select (`cs`) and serial data out (`mosi`), and it samples serial data in (`miso`). Each transfer sends one `width`-bit word MSB-first while receiving one word in parallel. It sits between core logic (parallel word and start/done handshake) and the pins or a synchronous shift-register peripheral on the same clock.

## Interface
- `width`, 8: word length in bits; minimum 2.
- `CLKDIV`, 4: length of each `sclk` half-period, in `clk` cycles; minimum 1.

- `clk`  input  1  FPGA clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a transfer; sampled only in IDLE.
- `txData`  input  width  word to send; latched on the accepting edge.
- `busy`  output  1  high while a transfer is in progress.
- `done`  output  1  one-cycle pulse when `rxData` is valid.
- `rxData`  output  width  last received word; holds until the next `done`.
- `sclk`  output  1  peripheral clock; idles low (mode 0).
- `cs`  output  1  chip select, active low; idles high.
- `mosi`  output  1  serial data out, MSB first.
- `miso`  input  1  serial data in, MSB first.

## Operation
- All outputs are registered. Reset (asynchronous): state IDLE, `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rxData`=0, internal shift registers, bit counter and divider counter=0.
- States: IDLE, SETUP, HIGH, LOW, FINISH. A divider counter counts `CLKDIV` cycles in each non-IDLE state.
- IDLE:
  - On `start`=1, load `tx`←`txData` and drive `cs`←0, `mosi`←`txData[width-1]`, `busy`←1. Go to SETUP.
  - `done` is low in every cycle except the single pulse from FINISH.
- SETUP: hold `sclk`=0 for `CLKDIV` cycles. On the last cycle, drive `sclk`←1, sample `rx`←{`rx[width-2:0]`,`miso`}, go to HIGH.
- HIGH:
  - After `CLKDIV` cycles, drive `sclk`←0 and increment the bit counter.
  - If `width` bits are complete, go to FINISH with `mosi` held.
  - Otherwise shift `tx` left, drive `mosi`←next bit, and go to LOW.
- LOW: after `CLKDIV` cycles, drive `sclk`←1, sample `miso` into `rx`, go to HIGH.
- FINISH: after `CLKDIV` cycles with `sclk`=0, drive `cs`←1, `busy`←0, `rxData`←`rx`, `done`←1 for one cycle, `mosi`←0. Go to IDLE.
- `start` while busy is ignored. `txData` changes after acceptance have no effect.
- `miso` is sampled on the same `clk` edge that raises `sclk`, i.e. before a synchronous peripheral detects that edge and shifts. The peripheral's MSB is therefore the first bit received.
- `mosi` changes only on edges that lower `sclk`, or on the accepting edge. It is stable for the whole high phase.

## Timing
- Let T0 be the edge that accepts `start`.
  - `cs` falls and `busy` rises at T0.
  - The k-th `sclk` rise (k=0..width-1) occurs at T0+CLKDIV·(2k+1).
  - The k-th `sclk` fall occurs at T0+CLKDIV·(2k+2).
  - `cs` rises, `busy` falls and `done` pulses at T0+CLKDIV·(2·width+1).
- Transfer latency is CLKDIV·(2·width+1) cycles. The `sclk` period is 2·CLKDIV cycles, with 50% duty.
- Back-to-back transfers: `start` high during the `done` cycle is accepted on the next edge. `cs` is then high for exactly 1 cycle between words.
- Reset mid-transfer: outputs go to their reset values immediately. `rxData` is cleared. No `done` pulse is produced.
- CLKDIV=1: each state lasts 1 cycle. The ordering rules above still hold.

## Test plan
- Loopback (`miso`=`mosi`), width=8, CLKDIV=2, send 0xA5:
  - `done` pulses at T0+34.
  - `rxData`=0xA5.
  - Exactly 8 `sclk` rises, at T0+2, 6, …, 30.
  - `cs` low from T0 to T0+34.
- Against the shift-register peripheral on the same `clk` (`pclk`=`sclk`, `sdataIn`=`mosi`, `miso`=`sdataOut`):
  - Parallel-load the peripheral with 0x3C, then send 0xC3.
  - Expect `rxData`=0x3C and peripheral `pdataOut`=0xC3.
- Pulse `start` again at T0+10 with different `txData` -> ignored. Single `done` at T0+34. `rxData` is unaffected.
- Assert `reset` at T0+13:
  - `cs`=1, `sclk`=0, `busy`=0 and `rxData`=0 within the same cycle.
  - No `done` pulse.
  - A following `start` with 0x5A completes normally.
- Hold `start`=1 continuously with 0x81 then 0x7E, CLKDIV=1:
  - Two transfers of 17 cycles each.
  - `cs` high for exactly 1 cycle between them.
  - `rxData` follows the loopback values 0x81 then 0x7E.

Source files
------------

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: sends one width-bit word MSB-first on mosi and receives one word on miso.
// Latency: CLKDIV*(2*width+1) clk cycles from the accepting edge to the done pulse.
// Backpressure: start is only accepted in IDLE; requests made while busy are dropped.
module spi_initiator #(
  parameter int width  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] rxData,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int divW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int bitW = $clog2(width + 1);
  localparam logic [divW-1:0] divLast = divW'(CLKDIV - 1);
  localparam logic [bitW-1:0] bitLast = bitW'(width - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    FINISH
  } state_t;

  state_t           state;
  logic [divW-1:0]  divCnt;
  logic [bitW-1:0]  bitCnt;
  // The MSB goes straight to mosi at acceptance, so only the remaining bits are queued here.
  logic [width-2:0] txRem;
  logic [width-1:0] rx;
  logic             divEnd;

  assign divEnd = (divCnt == divLast);

  // Transfer sequencer: every output is a register updated by this single process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      divCnt <= '0;
      bitCnt <= '0;
      txRem  <= '0;
      rx     <= '0;
      rxData <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      cs     <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          divCnt <= '0;
          if (start) begin
            txRem  <= txData[width-2:0];
            mosi   <= txData[width-1];
            cs     <= 1'b0;
            busy   <= 1'b1;
            bitCnt <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (divEnd) begin
            divCnt <= '0;
            sclk   <= 1'b1;
            // Sample on the edge that raises sclk, before a same-clock peripheral shifts.
            rx     <= {rx[width-2:0], miso};
            state  <= HIGH;
          end else begin
            divCnt <= divCnt + divW'(1);
          end
        end
        HIGH: begin
          if (divEnd) begin
            divCnt <= '0;
            sclk   <= 1'b0;
            bitCnt <= bitCnt + bitW'(1);
            if (bitCnt == bitLast) begin
              // Last bit stays on mosi through the FINISH hold time.
              state <= FINISH;
            end else begin
              mosi  <= txRem[width-2];
              txRem <= txRem << 1;
              state <= LOW;
            end
          end else begin
            divCnt <= divCnt + divW'(1);
          end
        end
        LOW: begin
          if (divEnd) begin
            divCnt <= '0;
            sclk   <= 1'b1;
            rx     <= {rx[width-2:0], miso};
            state  <= HIGH;
          end else begin
            divCnt <= divCnt + divW'(1);
          end
        end
        FINISH: begin
          if (divEnd) begin
            divCnt <= '0;
            cs     <= 1'b1;
            busy   <= 1'b0;
            rxData <= rx;
            done   <= 1'b1;
            mosi   <= 1'b0;
            state  <= IDLE;
          end else begin
            divCnt <= divCnt + divW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_initiator.sv
// Bench for spi_initiator: randomized loopback and shift-register-peripheral transfers,
// ignored mid-transfer start, mid-transfer reset, and back-to-back words at CLKDIV=1.
// Expected waveforms are computed from the transfer timing formulas relative to the accepting edge.
module tb_spi_initiator;

  localparam int W    = 8;
  localparam int DIV  = 2;
  localparam int LAT  = DIV * (2 * W + 1);
  localparam int LATB = 2 * W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] txData = '0;
  logic         busy, done, sclk, cs, mosi, miso;
  logic [W-1:0] rxData;

  logic         resetB = 1'b1;
  logic         startB = 1'b0;
  logic [W-1:0] txDataB = '0;
  logic         busyB, doneB, sclkB, csB, mosiB;
  logic [W-1:0] rxDataB;

  // Synchronous shift-register peripheral on the same clock: it shifts on the clk edge
  // after it sees its pclk go high, and presents its MSB on sdataOut.
  logic         loopback = 1'b1;
  logic         pLoad = 1'b0;
  logic [W-1:0] pLoadVal = '0;
  logic [W-1:0] pReg = '0;
  logic         sclkQ = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prevRx = '0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : pReg[W-1];

  always @(posedge clk) begin
    sclkQ <= sclk;
    if (pLoad) pReg <= pLoadVal;
    else if (sclk && !sclkQ) pReg <= {pReg[W-2:0], mosi};
  end

  spi_initiator #(.width(W), .CLKDIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .txData(txData),
    .busy(busy), .done(done), .rxData(rxData),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  spi_initiator #(.width(W), .CLKDIV(1)) dutB (
    .clk(clk), .reset(resetB), .start(startB), .txData(txDataB),
    .busy(busyB), .done(doneB), .rxData(rxDataB),
    .sclk(sclkB), .cs(csB), .mosi(mosiB), .miso(mosiB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer on the main DUT. ignoreAt/resetAt > 0 inject a start pulse or a reset
  // that takes effect at edge T0+ignoreAt / during the cycle before edge T0+resetAt.
  task automatic xfer(input logic [W-1:0] tx, input bit lb, input logic [W-1:0] pre,
                      input int ignoreAt, input int resetAt);
    int dones, rises, q, k;
    bit prevSclk, aborted, expSclk, expMosi;
    logic [W-1:0] expRx;
    loopback = lb;
    if (!lb) begin
      pLoadVal = pre;
      pLoad = 1'b1;
      @(negedge clk);
      pLoad = 1'b0;
    end
    expRx = lb ? tx : pre;
    txData = tx;
    start = 1'b1;
    @(negedge clk);
    txData = W'($urandom);
    dones = 0; rises = 0; prevSclk = 1'b0; aborted = 1'b0;
    for (int t = 0; t <= LAT + 1; t++) begin
      q = t / DIV;
      expSclk = (q % 2 == 1) && (q < 2 * W);
      k = t / (2 * DIV);
      if (k > W - 1) k = W - 1;
      expMosi = (t < LAT) ? tx[W-1-k] : 1'b0;
      check("sclk", sclk, expSclk);
      check("cs", cs, !(t < LAT));
      check("busy", busy, t < LAT);
      check("done", done, t == LAT);
      check("mosi", mosi, expMosi);
      check("rxData", rxData, (t < LAT) ? prevRx : expRx);
      if (sclk && !prevSclk) rises++;
      prevSclk = sclk;
      if (done) dones++;
      start = 1'b0;
      if (ignoreAt > 0 && t == ignoreAt - 1) begin
        start = 1'b1;
        txData = ~tx;
      end
      if (resetAt > 0 && t == resetAt - 1) begin
        #2 reset = 1'b1;
        #1;
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_rxData", rxData, '0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (aborted) begin
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < LAT; c++) begin
        @(negedge clk);
        check("post_rst_done", done, 1'b0);
        check("post_rst_cs", cs, 1'b1);
        check("post_rst_busy", busy, 1'b0);
      end
      prevRx = '0;
    end else begin
      check("done_count", dones, 1);
      check("sclk_rises", rises, W);
      check("rx_final", rxData, expRx);
      if (!lb) check("periph_out", pReg, tx);
      prevRx = expRx;
    end
  endtask

  initial begin
    logic [W-1:0] rtx, rpre;
    bit rlb;
    bit expCsB, expDoneB;
    @(negedge clk);
    @(negedge clk);
    check("reset_cs", cs, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rxData", rxData, '0);
    reset = 1'b0;
    resetB = 1'b0;
    @(negedge clk);

    xfer(8'hA5, 1'b1, 8'h00, 0, 0);
    xfer(8'hC3, 1'b0, 8'h3C, 0, 0);
    xfer(8'h69, 1'b1, 8'h00, 10, 0);
    xfer(8'hF0, 1'b1, 8'h00, 0, 13);
    xfer(8'h5A, 1'b1, 8'h00, 0, 0);

    for (int n = 0; n < 12; n++) begin
      rtx  = W'($urandom);
      rpre = W'($urandom);
      rlb  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(rtx, rlb, rpre, (n % 3 == 0) ? int'($urandom_range(2, LAT - 1)) : 0, 0);
    end

    // Back-to-back at CLKDIV=1 with start held high.
    startB = 1'b1;
    txDataB = 8'h81;
    @(negedge clk);
    for (int t = 0; t <= 2 * LATB + 3; t++) begin
      expCsB   = !((t < LATB) || (t > LATB && t < 2 * LATB + 1));
      expDoneB = (t == LATB) || (t == 2 * LATB + 1);
      check("b_cs", csB, expCsB);
      check("b_done", doneB, expDoneB);
      if (t == LATB) check("b_rx1", rxDataB, 8'h81);
      if (t == 2 * LATB + 1) check("b_rx2", rxDataB, 8'h7E);
      txDataB = 8'h7E;
      if (t == 2 * LATB + 1) startB = 1'b0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
